// File: rtl/adder8_feeder_if.sv
// Bus bundle between the sample stream, the adder tree and the result stream.
// The master view belongs to the feeder; the slave view belongs to whatever
// surrounds it (sample source, adder tree, result sink).
interface adder8_feeder_if;
  logic [11:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [95:0] row_out;
  logic [14:0] sum_in;
  logic [14:0] m_data;
  logic        m_valid;
  logic        m_ready;

  modport master (
    input  s_data, s_valid, sum_in, m_ready,
    output s_ready, row_out, m_data, m_valid
  );

  modport slave (
    output s_data, s_valid, sum_in, m_ready,
    input  s_ready, row_out, m_data, m_valid
  );
endinterface

// File: rtl/adder8_feeder.sv
// adder8_feeder: gathers serial 12-bit samples into rows of eight, issues each
// row to a fixed-latency adder tree with no handshake of its own, and catches
// the returning sums in a small FIFO. Issue is credit-limited so that every
// row in flight already has a FIFO slot reserved for its result.
module adder8_feeder #(
  parameter int LAT   = 5,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  adder8_feeder_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [2:0]     idx;
  logic           row_pend;
  logic [95:0]    row_q;
  logic [LAT-1:0] vld_sr;
  logic [CW-1:0]  outstanding;
  logic [14:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;

  logic accept;
  logic issue;
  logic push;
  logic pop;
  logic not_empty;

  // A full row blocks the input until the adder tree has taken it.
  assign bus.s_ready = !row_pend;
  assign accept      = bus.s_valid & !row_pend;
  // Only issue when a FIFO slot is guaranteed for the result.
  assign issue       = row_pend & (outstanding < DEPTH_C);
  // The tree's result is valid exactly LAT cycles after its row was issued.
  assign push        = vld_sr[LAT-1];
  assign not_empty   = (fifo_count != '0);
  assign pop         = not_empty & bus.m_ready;

  assign bus.row_out = row_q;
  assign bus.m_valid = not_empty;
  assign bus.m_data  = not_empty ? mem[rd_ptr] : '0;

  // Collector: place each accepted sample in its slot and flag a complete row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      row_pend <= 1'b0;
      row_q    <= '0;
    end else if (accept) begin
      row_q[int'(idx)*12 +: 12] <= bus.s_data;
      idx <= idx + 3'd1;
      if (idx == 3'd7) begin
        row_pend <= 1'b1;
      end
    end else if (issue) begin
      row_pend <= 1'b0;
    end
  end

  // Tracks which adder pipeline slots carry a real row rather than garbage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], issue};
    end
  end

  // Credits: rows issued but whose results have not yet left the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // FIFO pointers and occupancy; write and pop may coincide at any fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.sum_in;
    end
  end

endmodule
